// File: rtl/iob_axis_packer_pkg.sv
// rtl/iob_axis_packer_pkg.sv - shared defaults, close-cause type and lane width helper for iob_axis_packer
package iob_axis_packer_pkg;

  localparam int DEF_IN_W      = 8;
  localparam int DEF_OUT_W     = 32;
  localparam int DEF_TIMEOUT_W = 16;

  // Why the word in the pack buffer is being closed this cycle
  typedef enum logic [1:0] {
    CLOSE_NONE,
    CLOSE_FULL,
    CLOSE_LAST,
    CLOSE_FLUSH
  } close_e;

  // Lane counter width; kept at least one bit so RATIO==1 still has a legal vector
  function automatic int lane_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/iob_axis_packer_timer.sv
// rtl/iob_axis_packer_timer.sv - idle counter that flushes a partial word after timeout_i idle cycles
module iob_axis_packer_timer #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 expire_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  // The edge that would make the count equal timeout_i is the flush edge
  assign expire_o = run_i && (timeout_i != '0) && (cnt_q == timeout_i - 1'b1);
  assign cnt_d    = run_i ? cnt_q + 1'b1 : '0;

  // Idle cycle counter; any cycle that is not idle-with-partial-word restarts it
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else if (cke_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iob_reg_e.sv
// rtl/iob_reg_e.sv - enabled register with async active-low reset, clock enable and sync clear
module iob_reg_e #(
  parameter int DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  // Capture data_i when enabled; sync clear and clock enable gate every update
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_q <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        data_q <= '0;
      end else if (en_i) begin
        data_q <= data_i;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/iob_axis_packer.sv
// rtl/iob_axis_packer.sv - packs IN_W-bit AXIS beats into OUT_W-bit words; IOB_AXIS_PACKER_TIMEOUT_EN adds idle flush
module iob_axis_packer
  import iob_axis_packer_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
`ifdef IOB_AXIS_PACKER_TIMEOUT_EN
  , parameter int TIMEOUT_W = DEF_TIMEOUT_W
`endif
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   cke_i,
  input  logic                   rst_i,
  input  logic [IN_W-1:0]        in_tdata_i,
  input  logic                   in_tvalid_i,
  output logic                   in_tready_o,
  input  logic                   in_tlast_i,
  output logic [OUT_W-1:0]       out_tdata_o,
  output logic [OUT_W/IN_W-1:0]  out_tkeep_o,
  output logic                   out_tvalid_o,
  input  logic                   out_tready_i,
  output logic                   out_tlast_o,
  output logic [31:0]            word_cnt_o
`ifdef IOB_AXIS_PACKER_TIMEOUT_EN
  , input logic [TIMEOUT_W-1:0]  timeout_i
`endif
);

  localparam int RATIO  = OUT_W / IN_W;
  localparam int LANE_W = lane_w(RATIO);
  localparam int OREG_W = OUT_W + RATIO + 2;

  if (OUT_W % IN_W != 0) begin : g_ratio_chk
    $error("iob_axis_packer: OUT_W must be an integer multiple of IN_W");
  end

  logic [OUT_W-1:0]  pack_data_q, pack_data_d;
  logic [RATIO-1:0]  pack_keep_q, pack_keep_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              closed_q, closed_d;
  logic              pack_last_q, pack_last_d;
  logic [31:0]       word_cnt_q, word_cnt_d;

  logic              accept, out_free, flush, idle_run, load, oreg_en;
  close_e            cause;
  logic [OUT_W-1:0]  beat_data, word_data, ld_data;
  logic [RATIO-1:0]  beat_keep, word_keep, ld_keep;
  logic              word_last, ld_last;
  logic [OREG_W-1:0] oreg_d, oreg_q;

  assign accept    = in_tvalid_i & ~closed_q;
  assign out_free  = ~out_tvalid_o | out_tready_i;
  assign beat_data = pack_data_q | (OUT_W'(in_tdata_i) << (lane_q * IN_W));
  assign beat_keep = pack_keep_q | (RATIO'(1) << lane_q);
  assign idle_run  = (lane_q != '0) & ~closed_q & ~accept;

`ifdef IOB_AXIS_PACKER_TIMEOUT_EN
  iob_axis_packer_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .rst_i    (rst_i),
    .run_i    (idle_run),
    .timeout_i(timeout_i),
    .expire_o (flush)
  );
`else
  assign flush = 1'b0;
`endif

  // Classify the close event; an accepted beat always beats a timeout flush
  always_comb begin
    cause = CLOSE_NONE;
    if (accept && in_tlast_i)                         cause = CLOSE_LAST;
    else if (accept && (lane_q == LANE_W'(RATIO - 1))) cause = CLOSE_FULL;
    else if (flush && idle_run)                        cause = CLOSE_FLUSH;
    word_data = (cause == CLOSE_FLUSH) ? pack_data_q : beat_data;
    word_keep = (cause == CLOSE_FLUSH) ? pack_keep_q : beat_keep;
    word_last = (cause == CLOSE_LAST);
  end

  // Pack buffer next state and hand-off of closed words into the output register
  always_comb begin
    pack_data_d = pack_data_q;
    pack_keep_d = pack_keep_q;
    lane_d      = lane_q;
    closed_d    = closed_q;
    pack_last_d = pack_last_q;
    load        = 1'b0;
    ld_data     = word_data;
    ld_keep     = word_keep;
    ld_last     = word_last;
    if (closed_q) begin
      if (out_free) begin
        load        = 1'b1;
        ld_data     = pack_data_q;
        ld_keep     = pack_keep_q;
        ld_last     = pack_last_q;
        pack_data_d = '0;
        pack_keep_d = '0;
        pack_last_d = 1'b0;
        closed_d    = 1'b0;
      end
    end else if (cause != CLOSE_NONE) begin
      lane_d = '0;
      if (out_free) begin
        load        = 1'b1;
        pack_data_d = '0;
        pack_keep_d = '0;
      end else begin
        pack_data_d = word_data;
        pack_keep_d = word_keep;
        pack_last_d = word_last;
        closed_d    = 1'b1;
      end
    end else if (accept) begin
      pack_data_d = beat_data;
      pack_keep_d = beat_keep;
      lane_d      = lane_q + LANE_W'(1);
    end
  end

  assign word_cnt_d = word_cnt_q + {31'd0, out_tvalid_o & out_tready_i};

  // Pack buffer and word counter registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pack_data_q <= '0;
      pack_keep_q <= '0;
      lane_q      <= '0;
      closed_q    <= 1'b0;
      pack_last_q <= 1'b0;
      word_cnt_q  <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        pack_data_q <= '0;
        pack_keep_q <= '0;
        lane_q      <= '0;
        closed_q    <= 1'b0;
        pack_last_q <= 1'b0;
        word_cnt_q  <= '0;
      end else begin
        pack_data_q <= pack_data_d;
        pack_keep_q <= pack_keep_d;
        lane_q      <= lane_d;
        closed_q    <= closed_d;
        pack_last_q <= pack_last_d;
        word_cnt_q  <= word_cnt_d;
      end
    end
  end

  // Output register updates on a new word or when the held word is taken
  assign oreg_en = load | (out_tvalid_o & out_tready_i);
  assign oreg_d  = load ? {ld_data, ld_keep, ld_last, 1'b1}
                        : {out_tdata_o, out_tkeep_o, out_tlast_o, 1'b0};

  iob_reg_e #(
    .DATA_W(OREG_W)
  ) u_out_reg (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .cke_i   (cke_i),
    .rst_i   (rst_i),
    .en_i    (oreg_en),
    .data_i  (oreg_d),
    .data_o  (oreg_q)
  );

  assign {out_tdata_o, out_tkeep_o, out_tlast_o, out_tvalid_o} = oreg_q;
  assign in_tready_o = ~closed_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_iob_axis_packer.sv
// tb/tb_iob_axis_packer.sv - randomized and directed self-checking bench for iob_axis_packer
module tb_iob_axis_packer;

  localparam int IN_W  = 8;
  localparam int OUT_W = 32;
  localparam int RATIO = OUT_W / IN_W;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             cke = 1'b1;
  logic             rst = 1'b0;
  logic [IN_W-1:0]  in_tdata = '0;
  logic             in_tvalid = 1'b0;
  logic             in_tready;
  logic             in_tlast = 1'b0;
  logic [OUT_W-1:0] out_tdata;
  logic [RATIO-1:0] out_tkeep;
  logic             out_tvalid;
  logic             out_tready = 1'b0;
  logic             out_tlast;
  logic [31:0]      word_cnt;
  logic [15:0]      tmo = '0;

  iob_axis_packer dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .cke_i       (cke),
    .rst_i       (rst),
    .in_tdata_i  (in_tdata),
    .in_tvalid_i (in_tvalid),
    .in_tready_o (in_tready),
    .in_tlast_i  (in_tlast),
    .out_tdata_o (out_tdata),
    .out_tkeep_o (out_tkeep),
    .out_tvalid_o(out_tvalid),
    .out_tready_i(out_tready),
    .out_tlast_o (out_tlast),
    .word_cnt_o  (word_cnt)
`ifdef IOB_AXIS_PACKER_TIMEOUT_EN
    , .timeout_i (tmo)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [RATIO-1:0] k;
    logic             l;
  } word_t;

  word_t            exp_q[$];
  logic [OUT_W-1:0] m_data;
  logic [RATIO-1:0] m_keep;
  int               m_n, m_idle;
  logic [31:0]      n_xfer;
  bit               hold_pending;
  logic [OUT_W-1:0] hold_d;
  logic [RATIO-1:0] hold_k;
  logic             hold_l;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_data = '0; m_keep = '0; m_n = 0; m_idle = 0;
    n_xfer = '0;
    hold_pending = 1'b0;
  endtask

  task automatic model_close(input logic last);
    word_t w;
    w.d = m_data; w.k = m_keep; w.l = last;
    exp_q.push_back(w);
    m_data = '0; m_keep = '0; m_n = 0; m_idle = 0;
  endtask

  // Evaluate the handshakes of the coming edge, check, update the model, advance one cycle
  task automatic tick();
    bit acc;
    bit xfer;
    word_t w;
    acc  = cke && in_tvalid && in_tready;
    xfer = cke && out_tvalid && out_tready;
    if (hold_pending) begin
      check_eq("hold_valid", out_tvalid, 1);
      check_eq("hold_data", out_tdata, hold_d);
      check_eq("hold_keep", out_tkeep, hold_k);
      check_eq("hold_last", out_tlast, hold_l);
    end
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check_eq("word_data", out_tdata, w.d);
        check_eq("word_keep", out_tkeep, w.k);
        check_eq("word_last", out_tlast, w.l);
      end
      n_xfer++;
    end
    hold_pending = out_tvalid && !xfer;
    hold_d = out_tdata; hold_k = out_tkeep; hold_l = out_tlast;
    if (acc) begin
      m_data = m_data | (OUT_W'(in_tdata) << (m_n * IN_W));
      m_keep = m_keep | (RATIO'(1) << m_n);
      m_n++;
      m_idle = 0;
      if (in_tlast || m_n == RATIO) model_close(in_tlast);
    end else if (cke && m_n > 0) begin
      m_idle++;
      if (tmo != 0 && m_idle == int'(tmo)) model_close(1'b0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [IN_W-1:0] d, input logic last);
    in_tvalid = 1'b1; in_tdata = d; in_tlast = last;
    tick();
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, out_tvalid, 0);
    check_eq({tag, "_data"}, out_tdata, 0);
    check_eq({tag, "_keep"}, out_tkeep, 0);
    check_eq({tag, "_last"}, out_tlast, 0);
    check_eq({tag, "_cnt"}, word_cnt, 0);
    check_eq({tag, "_ready"}, in_tready, 1);
  endtask

  task automatic do_arst();
    arst_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    bit ready_seen_low;
    model_clear();
    @(negedge clk);
    do_arst();

    // Full words, sustained throughput
    out_tready = 1'b1;
    ready_seen_low = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!in_tready) ready_seen_low = 1'b1;
      beat(IN_W'(i * 'h11), 1'b0);
    end
    check_eq("full_w2_data", out_tdata, 32'h88776655);
    tick();
    check_eq("full_ready_low", ready_seen_low, 0);
    check_eq("full_cnt", word_cnt, 2);

    // Early tlast and one-cycle latency
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    check_eq("tlast_valid", out_tvalid, 1);
    check_eq("tlast_data", out_tdata, 32'h0000BBAA);
    check_eq("tlast_keep", out_tkeep, 4'h3);
    check_eq("tlast_last", out_tlast, 1);
    tick();

    // Backpressure: output stalled while input keeps streaming
    out_tready = 1'b0;
    in_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_tdata = IN_W'(8'h30 + i);
      tick();
    end
    in_tvalid = 1'b0;
    check_eq("bp_ready_low", in_tready, 0);
    out_tready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("bp_ready_back", in_tready, 1);
    check_eq("bp_drained", exp_q.size(), 0);
    check_eq("bp_cnt", word_cnt, n_xfer);

`ifdef IOB_AXIS_PACKER_TIMEOUT_EN
    // Idle timeout flush, then a beat on the expiry cycle
    tmo = 16'd5;
    beat(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("tmo_early", out_tvalid, 0);
    tick();
    check_eq("tmo_valid", out_tvalid, 1);
    check_eq("tmo_data", out_tdata, 32'h0000005A);
    check_eq("tmo_keep", out_tkeep, 4'h1);
    check_eq("tmo_last", out_tlast, 0);
    tick();
    beat(8'h01, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    beat(8'h02, 1'b0);
    check_eq("tmo_race_noflush", out_tvalid, 0);
    beat(8'h03, 1'b1);
    check_eq("tmo_race_data", out_tdata, 32'h00030201);
    tick();
    tmo = '0;
`endif

    // Async reset mid-word drops the partial word
    beat(8'hE1, 1'b0);
    beat(8'hE2, 1'b0);
    do_arst();
    for (int i = 1; i <= 4; i++) beat(IN_W'(i), 1'b0);
    check_eq("arst_clean_data", out_tdata, 32'h04030201);
    check_eq("arst_clean_keep", out_tkeep, 4'hF);
    tick();

    // Synchronous clear mid-word, with a word also waiting on the output
    out_tready = 1'b0;
    for (int i = 0; i < 6; i++) beat(IN_W'(8'hC0 + i), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_idle_outputs("srst");
    out_tready = 1'b1;
    beat(8'h77, 1'b1);
    check_eq("srst_after_data", out_tdata, 32'h00000077);
    tick();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
`ifdef IOB_AXIS_PACKER_TIMEOUT_EN
      if (i % 200 == 0) tmo = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
`endif
      in_tvalid  = ($urandom_range(0, 9) < 7);
      in_tdata   = IN_W'($urandom);
      in_tlast   = ($urandom_range(0, 9) < 2);
      out_tready = ($urandom_range(0, 9) < 6);
      cke        = ($urandom_range(0, 9) != 0);
      tick();
    end
    in_tvalid = 1'b0; in_tlast = 1'b0; out_tready = 1'b1; cke = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("rand_drained", exp_q.size(), 0);
    check_eq("rand_cnt", word_cnt, n_xfer);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
